rsa_control: RTL and testbench

// - Single-key RSA engine: derives n=p*q, phi=(p-1)*(q-1), private d = e^-1 mod phi.
// - Then computes msg_out = msg_in^k mod n, with k=e (encrypt) or k=d (decrypt).
// - Two independently started multi-cycle phases: modular inverter, then modular exponentiator.
// - Two instances back to back (encrypt into decrypt, same p/q) must return the original message.

---
 rtl/rsa_control_if.sv | 28 ++
 rtl/rsa_control.sv | 277 +++++++++++++++++++++++++++
 tb/tb_rsa_control.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/rsa_control_if.sv
`default_nettype none
// ============================================================================
// Module   : rsa_control_if
// Brief    : Key, message and result bundle for the rsa_control engine.
// Revision : 1.0 - initial release
// ============================================================================
interface rsa_control_if #(
  parameter int WIDTH = 128
);
  logic [WIDTH-1:0]   p;
  logic [WIDTH-1:0]   q;
  logic               encrypt_decrypt;
  logic [2*WIDTH-1:0] msg_in;
  logic               inverter_finish;
  logic [2*WIDTH-1:0] msg_out;
  logic               mod_exp_finish;

  modport master (
    output p, q, encrypt_decrypt, msg_in,
    input  inverter_finish, msg_out, mod_exp_finish
  );

  modport slave (
    input  p, q, encrypt_decrypt, msg_in,
    output inverter_finish, msg_out, mod_exp_finish
  );
endinterface
`default_nettype wire

// File: rtl/rsa_control.sv
`default_nettype none
// ============================================================================
// Module   : rsa_control
// Brief    : RSA key derivation (d = e^-1 mod phi) and modular exponentiation.
// Revision : 1.0 - initial release
// ============================================================================
module rsa_control #(
  parameter int WIDTH = 128
) (
  input  logic         clk,
  input  logic         reset_inverter,
  input  logic         reset_mod_exp,
  rsa_control_if.slave bus
);
  localparam int MW = 2 * WIDTH;
  localparam int PW = 2 * WIDTH + 2;
  localparam int CW = $clog2(PW) + 1;
  localparam logic [MW-1:0]        E_EXP   = MW'(65537);
  localparam logic [PW-1:0]        E_PUB   = {2'b00, E_EXP};
  localparam logic signed [PW-1:0] T_ONE   = 1;
  localparam logic [PW-1:0]        RES_ONE = 1;

  // ---------------------------------------------------------------- inverter
  typedef enum logic [2:0] {
    INV_ALIGN = 3'd0,
    INV_SUB   = 3'd1,
    INV_SWAP  = 3'd2,
    INV_FIN   = 3'd3,
    INV_DONE  = 3'd4
  } inv_state_t;

  inv_state_t           inv_state_q, inv_state_d;
  logic                 inv_finish_q, inv_finish_d;
  logic [PW-1:0]        r0_q, r0_d, r1_q, r1_d, sr_q, sr_d;
  logic signed [PW-1:0] t0_q, t0_d, t1_q, t1_d, st_q, st_d;
  logic [CW-1:0]        sh_q, sh_d;
  logic [MW-1:0]        n_q, n_d, phi_q, phi_d, d_q, d_d;
  logic [MW-1:0]        w_n, w_phi;

  assign w_n   = {{WIDTH{1'b0}}, bus.p} * {{WIDTH{1'b0}}, bus.q};
  assign w_phi = {{WIDTH{1'b0}}, bus.p - WIDTH'(1)} * {{WIDTH{1'b0}}, bus.q - WIDTH'(1)};

  // Euclid quotient by shift-subtract: align r1 under r0, then peel bits off,
  // updating the Bezout coefficient with the same shifted subtrahends.
  always_comb begin
    inv_state_d  = inv_state_q;
    inv_finish_d = inv_finish_q;
    r0_d  = r0_q;
    r1_d  = r1_q;
    sr_d  = sr_q;
    t0_d  = t0_q;
    t1_d  = t1_q;
    st_d  = st_q;
    sh_d  = sh_q;
    n_d   = n_q;
    phi_d = phi_q;
    d_d   = d_q;
    case (inv_state_q)
      INV_ALIGN: begin
        if ((sr_q << 1) <= r0_q) begin
          sr_d = sr_q << 1;
          st_d = st_q <<< 1;
          sh_d = sh_q + CW'(1);
        end else begin
          inv_state_d = INV_SUB;
        end
      end
      INV_SUB: begin
        if (r0_q >= sr_q) begin
          r0_d = r0_q - sr_q;
          t0_d = t0_q - st_q;
        end
        if (sh_q == '0) begin
          inv_state_d = INV_SWAP;
        end else begin
          sr_d = sr_q >> 1;
          st_d = st_q >>> 1;
          sh_d = sh_q - CW'(1);
        end
      end
      INV_SWAP: begin
        r0_d = r1_q;
        r1_d = r0_q;
        t0_d = t1_q;
        t1_d = t0_q;
        sr_d = r0_q;
        st_d = t0_q;
        sh_d = '0;
        inv_state_d = (r0_q == '0) ? INV_FIN : INV_ALIGN;
      end
      INV_FIN: begin
        if (r0_q == RES_ONE) begin
          d_d = t0_q[PW-1] ? (t0_q[MW-1:0] + phi_q) : t0_q[MW-1:0];
        end else begin
          d_d = '0;
        end
        inv_finish_d = 1'b1;
        inv_state_d  = INV_DONE;
      end
      INV_DONE: begin
        inv_state_d = INV_DONE;
      end
      default: begin
        inv_state_d = INV_DONE;
      end
    endcase
    if (reset_inverter) begin
      n_d   = w_n;
      phi_d = w_phi;
      r0_d  = {2'b00, w_phi};
      r1_d  = E_PUB;
      sr_d  = E_PUB;
      t0_d  = '0;
      t1_d  = T_ONE;
      st_d  = T_ONE;
      sh_d  = '0;
      d_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset_inverter) begin
    if (reset_inverter) begin
      inv_state_q  <= INV_ALIGN;
      inv_finish_q <= 1'b0;
    end else begin
      inv_state_q  <= inv_state_d;
      inv_finish_q <= inv_finish_d;
    end
  end

  // Datapath is (re)loaded on clock edges while the phase reset is high.
  always_ff @(posedge clk) begin
    r0_q  <= r0_d;
    r1_q  <= r1_d;
    sr_q  <= sr_d;
    t0_q  <= t0_d;
    t1_q  <= t1_d;
    st_q  <= st_d;
    sh_q  <= sh_d;
    n_q   <= n_d;
    phi_q <= phi_d;
    d_q   <= d_d;
  end

  // ------------------------------------------------------------ exponentiator
  typedef enum logic [1:0] {
    EXP_RED  = 2'd0,
    EXP_MUL  = 2'd1,
    EXP_DONE = 2'd2
  } exp_state_t;

  exp_state_t    exp_state_q, exp_state_d;
  logic          exp_finish_q, exp_finish_d;
  logic [MW-1:0] msg_out_q, msg_out_d;
  logic [PW-1:0] nx_q, nx_d, acc_m_q, acc_m_d, acc_s_q, acc_s_d;
  logic [PW-1:0] res_q, res_d, base_q, base_d;
  logic [MW-1:0] b_q, b_d, e_q, e_d;
  logic [CW-1:0] bit_q, bit_d, rnd_q, rnd_d;
  logic [PW-1:0] w_acc_m, w_acc_s, w_res_next;
  logic          w_last;

  function automatic logic [PW-1:0] mod_step(input logic [PW-1:0] acc,
                                             input logic [PW-1:0] a,
                                             input logic [PW-1:0] n,
                                             input logic          b_in);
    logic [PW-1:0] t;
    t = acc << 1;
    if (t >= n) t = t - n;
    if (b_in)   t = t + a;
    if (t >= n) t = t - n;
    return t;
  endfunction

  // Two lanes share the multiplier bit stream: result*base and base*base.
  assign w_acc_m    = mod_step(acc_m_q, res_q, nx_q, b_q[MW-1]);
  assign w_acc_s    = mod_step(acc_s_q, base_q, nx_q, b_q[MW-1]);
  assign w_last     = (bit_q == CW'(MW - 1));
  assign w_res_next = e_q[0] ? w_acc_m : res_q;

  always_comb begin
    exp_state_d  = exp_state_q;
    exp_finish_d = exp_finish_q;
    msg_out_d    = msg_out_q;
    nx_d    = nx_q;
    acc_m_d = acc_m_q;
    acc_s_d = acc_s_q;
    res_d   = res_q;
    base_d  = base_q;
    b_d     = b_q;
    e_d     = e_q;
    bit_d   = bit_q;
    rnd_d   = rnd_q;
    case (exp_state_q)
      // 1 * msg_in mod n brings an oversized message into range first.
      EXP_RED: begin
        acc_m_d = w_acc_m;
        b_d     = b_q << 1;
        bit_d   = bit_q + CW'(1);
        if (w_last) begin
          base_d      = w_acc_m;
          acc_m_d     = '0;
          acc_s_d     = '0;
          b_d         = w_acc_m[MW-1:0];
          bit_d       = '0;
          exp_state_d = EXP_MUL;
        end
      end
      EXP_MUL: begin
        acc_m_d = w_acc_m;
        acc_s_d = w_acc_s;
        b_d     = b_q << 1;
        bit_d   = bit_q + CW'(1);
        if (w_last) begin
          res_d   = w_res_next;
          base_d  = w_acc_s;
          acc_m_d = '0;
          acc_s_d = '0;
          b_d     = w_acc_s[MW-1:0];
          bit_d   = '0;
          e_d     = e_q >> 1;
          rnd_d   = rnd_q + CW'(1);
          if (rnd_q == CW'(MW - 1)) begin
            msg_out_d    = w_res_next[MW-1:0];
            exp_finish_d = 1'b1;
            exp_state_d  = EXP_DONE;
          end
        end
      end
      EXP_DONE: begin
        exp_state_d = EXP_DONE;
      end
      default: begin
        exp_state_d = EXP_DONE;
      end
    endcase
    if (reset_mod_exp) begin
      nx_d    = {2'b00, n_q};
      acc_m_d = '0;
      acc_s_d = '0;
      res_d   = RES_ONE;
      base_d  = '0;
      b_d     = bus.msg_in;
      e_d     = bus.encrypt_decrypt ? d_q : E_EXP;
      bit_d   = '0;
      rnd_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset_mod_exp) begin
    if (reset_mod_exp) begin
      exp_state_q  <= EXP_RED;
      exp_finish_q <= 1'b0;
      msg_out_q    <= '0;
    end else begin
      exp_state_q  <= exp_state_d;
      exp_finish_q <= exp_finish_d;
      msg_out_q    <= msg_out_d;
    end
  end

  always_ff @(posedge clk) begin
    nx_q    <= nx_d;
    acc_m_q <= acc_m_d;
    acc_s_q <= acc_s_d;
    res_q   <= res_d;
    base_q  <= base_d;
    b_q     <= b_d;
    e_q     <= e_d;
    bit_q   <= bit_d;
    rnd_q   <= rnd_d;
  end

  assign bus.inverter_finish = inv_finish_q;
  assign bus.mod_exp_finish  = exp_finish_q;
  assign bus.msg_out         = msg_out_q;
endmodule
`default_nettype wire

// File: tb/tb_rsa_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_rsa_control
// Brief    : Directed checks of rsa_control: small textbook key plus a
//            64-bit-prime encrypt/decrypt round trip across two instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rsa_control;
  localparam int SW = 24;
  localparam int LW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_inv_s = 1'b0, rst_exp_s = 1'b0;
  logic rst_inv_a = 1'b0, rst_exp_a = 1'b0;
  logic rst_inv_b = 1'b0, rst_exp_b = 1'b0;

  rsa_control_if #(.WIDTH(SW)) bus_s ();
  rsa_control_if #(.WIDTH(LW)) bus_a ();
  rsa_control_if #(.WIDTH(LW)) bus_b ();

  rsa_control #(.WIDTH(SW)) u_small (
    .clk(clk), .reset_inverter(rst_inv_s), .reset_mod_exp(rst_exp_s), .bus(bus_s));
  rsa_control #(.WIDTH(LW)) u_enc (
    .clk(clk), .reset_inverter(rst_inv_a), .reset_mod_exp(rst_exp_a), .bus(bus_a));
  rsa_control #(.WIDTH(LW)) u_dec (
    .clk(clk), .reset_inverter(rst_inv_b), .reset_mod_exp(rst_exp_b), .bus(bus_b));

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] RT_MSG = 128'h7795ebe2596d9d;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_flag(input int sel);
    case (sel)
      0:       return bus_s.inverter_finish;
      1:       return bus_s.mod_exp_finish;
      2:       return bus_a.inverter_finish;
      3:       return bus_a.mod_exp_finish;
      4:       return bus_b.inverter_finish;
      default: return bus_b.mod_exp_finish;
    endcase
  endfunction

  task automatic wait_done(input int sel, input int limit, input string tag);
    int n = 0;
    while (get_flag(sel) !== 1'b1 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, {127'd0, get_flag(sel)}, 128'd1);
  endtask

  task automatic small_inv(input logic [SW-1:0] p, input logic [SW-1:0] q);
    bus_s.p = p;
    bus_s.q = q;
    rst_inv_s = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("inv_finish_low_in_reset", {127'd0, bus_s.inverter_finish}, 128'd0);
    rst_inv_s = 1'b0;
    wait_done(0, 3000, "small_inv_done");
  endtask

  task automatic small_exp(input logic [2*SW-1:0] msg, input logic ed,
                           input logic [127:0] exp, input string tag);
    bus_s.msg_in = msg;
    bus_s.encrypt_decrypt = ed;
    rst_exp_s = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_exp_s = 1'b0;
    wait_done(1, 3000, "small_exp_done");
    check(tag, {80'd0, bus_s.msg_out}, exp);
  endtask

  initial begin
    bus_s.p = '0; bus_s.q = '0; bus_s.msg_in = '0; bus_s.encrypt_decrypt = 1'b0;
    bus_a.p = '0; bus_a.q = '0; bus_a.msg_in = '0; bus_a.encrypt_decrypt = 1'b0;
    bus_b.p = '0; bus_b.q = '0; bus_b.msg_in = '0; bus_b.encrypt_decrypt = 1'b0;
    #2;
    rst_inv_s = 1'b1; rst_exp_s = 1'b1;
    rst_inv_a = 1'b1; rst_exp_a = 1'b1;
    rst_inv_b = 1'b1; rst_exp_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_inverter_finish", {127'd0, bus_s.inverter_finish}, 128'd0);
    check("reset_mod_exp_finish", {127'd0, bus_s.mod_exp_finish}, 128'd0);
    check("reset_msg_out", {80'd0, bus_s.msg_out}, 128'd0);

    // n = 3233, phi = 3120, d = 2753
    small_inv(24'd61, 24'd53);
    check("d_small_key", {80'd0, u_small.d_q}, 128'd2753);

    small_exp(48'd65,   1'b0, 128'd2790, "encrypt_65");
    small_exp(48'd2790, 1'b1, 128'd65,   "decrypt_2790");
    small_exp(48'd0,    1'b0, 128'd0,    "encrypt_zero");
    small_exp(48'd1,    1'b0, 128'd1,    "encrypt_one");
    small_exp(48'd1,    1'b1, 128'd1,    "decrypt_one");
    // 3298 = 65 + n, so it reduces to 65 before exponentiation
    small_exp(48'd3298, 1'b0, 128'd2790, "encrypt_above_n");

    // re-keying must leave the finished exponentiation result alone
    rst_inv_s = 1'b1;
    #1;
    check("inv_finish_async_clear", {127'd0, bus_s.inverter_finish}, 128'd0);
    check("msg_out_kept_on_inv_reset", {80'd0, bus_s.msg_out}, 128'd2790);
    check("exp_finish_kept_on_inv_reset", {127'd0, bus_s.mod_exp_finish}, 128'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_inv_s = 1'b0;
    wait_done(0, 3000, "small_inv_redo_done");
    check("d_after_rekey", {80'd0, u_small.d_q}, 128'd2753);

    // asynchronous clear of a finished result, then abort mid-run
    rst_exp_s = 1'b1;
    #1;
    check("abort_msg_out_zero", {80'd0, bus_s.msg_out}, 128'd0);
    check("abort_finish_zero", {127'd0, bus_s.mod_exp_finish}, 128'd0);
    bus_s.msg_in = 48'd2790;
    bus_s.encrypt_decrypt = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_exp_s = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    check("midrun_finish_low", {127'd0, bus_s.mod_exp_finish}, 128'd0);
    rst_exp_s = 1'b1;
    #1;
    check("midrun_abort_finish_low", {127'd0, bus_s.mod_exp_finish}, 128'd0);
    small_exp(48'd65, 1'b0, 128'd2790, "restart_encrypt_65");

    // gcd(65537, 262148) = 65537 -> no inverse
    small_inv(24'd131075, 24'd3);
    check("d_gcd_not_one", {80'd0, u_small.d_q}, 128'd0);

    // round trip on 64-bit primes
    bus_a.p = 64'd8475698667747010771;
    bus_a.q = 64'd11297384090418420749;
    bus_b.p = 64'd8475698667747010771;
    bus_b.q = 64'd11297384090418420749;
    @(posedge clk);
    #1;
    rst_inv_a = 1'b0;
    rst_inv_b = 1'b0;
    wait_done(2, 10000, "enc_inv_done");
    wait_done(4, 10000, "dec_inv_done");
    bus_a.msg_in = RT_MSG;
    bus_a.encrypt_decrypt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_exp_a = 1'b0;
    wait_done(3, 20000, "enc_exp_done");
    bus_b.msg_in = bus_a.msg_out;
    bus_b.encrypt_decrypt = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_exp_b = 1'b0;
    wait_done(5, 20000, "dec_exp_done");
    check("round_trip_msg", bus_b.msg_out, RT_MSG);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
